// File: rtl/data_mem_ctrl_if.sv
// Load/store port bundle between the datapath (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  ready;
    logic                  ack;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, ack, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, ack, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte-lane writes, programmable read latency and response strobes.
// Optional out-of-range detection is enabled with `define DATA_MEM_BOUNDS_CHECK_EN.
module data_mem_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned RD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        S_IDLE,
        S_RD_WAIT
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_ack;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_rd_oob;
    logic [DATA_W-1:0]   r_rd_word;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_word_addr;
    logic [IDX_W-1:0]    w_idx;
    logic                w_oob;
    logic                w_accept;
    logic                w_wr_en;

    // Byte address to word index; low lane bits are dropped (silent align-down).
    assign w_word_addr = bus.addr >> OFF_W;
    assign w_idx       = IDX_W'(w_word_addr);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    assign w_oob = (w_word_addr >= ADDR_W'(DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    assign w_accept = bus.req && r_ready;
    assign w_wr_en  = rst_n && w_accept && bus.we && !w_oob;

    // Storage and read sampling; no reset so the RAM survives rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
        if (w_accept && !bus.we) begin
            r_rd_word <= r_mem[w_idx];
        end
    end

    // Controller FSM and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rd_oob <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        if (bus.we) begin
                            r_ack <= 1'b1;
                            r_err <= w_oob;
                        end else begin
                            r_state  <= S_RD_WAIT;
                            r_ready  <= 1'b0;
                            r_cnt    <= CNT_W'(RD_LAT - 1);
                            r_rd_oob <= w_oob;
                            // Single-cycle latency answers straight from the array.
                            if (RD_LAT == 1) begin
                                r_rvalid <= 1'b1;
                                r_err    <= w_oob;
                                r_rdata  <= w_oob ? '0 : r_mem[w_idx];
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_rvalid <= 1'b1;
                            r_err    <= r_rd_oob;
                            r_rdata  <= r_rd_oob ? '0 : r_rd_word;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.ack    = r_ack;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign bus.err    = r_err;
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised single-port data memory with a request/ready handshake.
- Adds byte-lane write enables, programmable read latency and a response strobe.
- Sits on the datapath load/store port. The processor control unit stalls on ready=0 and takes load data on rvalid.
- Storage is inferred RAM. The controller FSM and the response registers are the only reset state.

Parameters:
- DATA_W, 32: data word width in bits; a multiple of 8.
- ADDR_W, 32: width of the byte address.
- DEPTH, 4096: number of words; power of 2.
- RD_LAT, 2: read latency in cycles, legal range 1..7.

Ports:
- clk  in  1  clock; every register updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte-lane write enables; lane i covers wdata[8i+7:8i].
- ready  out  1  controller can accept a request this cycle.
- ack  out  1  one-cycle pulse marking write completion.
- rvalid  out  1  one-cycle pulse; rdata is valid in this cycle.
- rdata  out  DATA_W  read data; 0 whenever rvalid=0.
- err  out  1  out-of-range flag, reported with ack/rvalid (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a posedge):
  - FSM goes to IDLE.
  - ready=1, ack=0, rvalid=0, rdata=0, err=0.
  - Latency counter = 0.
  - RAM contents are untouched.
  - A request pending at the reset edge is dropped with no response.
- Word index:
  - idx = addr >> log2(DATA_W/8).
  - The low log2(DATA_W/8) address bits are ignored, so misaligned addresses are silently aligned down.
- Acceptance: a request is accepted at a posedge where req=1 and ready=1.
- FSM states: IDLE and RD_WAIT.
- IDLE:
  - ready=1.
  - Write accepted:
    - At that same edge, mem[idx] lanes with be[i]=1 take wdata; lanes with be[i]=0 keep their old value.
    - ack=1 in the next cycle only.
    - FSM stays in IDLE, so back-to-back writes run at 1 per cycle.
    - be=0 performs no update but still produces ack.
  - Read accepted:
    - mem[idx] is sampled at the acceptance edge T.
    - FSM goes to RD_WAIT and the counter loads RD_LAT-1.
- RD_WAIT:
  - ready=0; req is ignored with no side effects.
  - The counter decrements each cycle.
  - rvalid=1 and rdata=sampled word in cycle T+RD_LAT.
  - FSM returns to IDLE at the end of that cycle, so ready=1 from cycle T+RD_LAT+1.
  - With RD_LAT=1: rvalid in cycle T+1, ready=0 only in cycle T+1.
- ack and rvalid are never asserted in the same cycle.
- Reset during RD_WAIT: the read is aborted, no rvalid, and ready=1 in the cycle after reset.
- No write can occur during RD_WAIT, so the read-then-write ordering is fixed.
- Read-after-write to the same idx in consecutive cycles returns the new data.

Optional Feature:
- Macro: DATA_MEM_BOUNDS_CHECK_EN.
- Defined:
  - An access with idx >= DEPTH is out of range.
  - Write: the RAM is not modified; ack=1 and err=1 in the next cycle.
  - Read: normal FSM timing; at T+RD_LAT, rvalid=1, err=1, rdata=0.
  - err is 0 in all other cycles.
- Not defined:
  - idx wraps modulo DEPTH, using only the low log2(DEPTH) bits.
  - err is tied to 0.

Test Plan (DATA_W=32, DEPTH=4096, RD_LAT=2 unless stated):
- Reset hold: rst_n=0 for 2 cycles with req=1 -> ready=1, ack=0, rvalid=0, rdata=0, err=0 after each edge; no RAM change.
- Write then read: write addr=0x10, wdata=0xDEADBEEF, be=4'hF at T0 -> ack=1 at T0+1. Read addr=0x10 at T0+1 -> ready=0 in cycles T0+2..T0+3; rvalid=1 with rdata=0xDEADBEEF at T0+3; ready=1 at T0+4.
- Byte lanes: after the previous step, write addr=0x10, wdata=0x00000055, be=4'b0001 -> a subsequent read returns 0xDEADBE55.
- Busy and reset: read accepted at T, second req=1 held during RD_WAIT -> not accepted, one rvalid only. Repeat with rst_n=0 at T+1 -> no rvalid, ready=1 at T+2.
- Latency sweep: RD_LAT=1 and RD_LAT=7, read addr=0x13 (aligned to idx 4) -> rvalid exactly 1 and 7 cycles after acceptance; rdata=mem[4].
- Bounds: write addr=0x4000 (idx 4096) with wdata=0x1234.
  - Macro defined -> ack=1, err=1, mem[0] unchanged; read addr=0x4000 -> rvalid=1, err=1, rdata=0.
  - Macro undefined -> mem[0]=0x1234, err=0.
